stage2_conv_ctrl: RTL and testbench

STAGE2_CONV_CTRL -- requirements
Module: stage2_conv_ctrl

---
 rtl/stage2_conv_ctrl_pkg.sv | 23 ++
 rtl/stage2_conv_ofifo.sv | 64 ++++++
 rtl/stage2_conv_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_stage2_conv_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stage2_conv_ctrl_pkg.sv
// Shared stage2 convolution constants: accumulator guard bits, kernel shape,
// controller state encodings and the output-credit helper.
package stage2_conv_ctrl_pkg;

   localparam int AO_GUARD = 4;
   localparam int KX       = 5;
   localparam int KY       = 5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // A slot being popped this cycle is already free for a new pixel.
   function automatic logic has_credit(input logic [1:0] occ,
                                       input logic       pop,
                                       input logic [1:0] inflight);
      logic [2:0] used;
      used = 3'(occ) + 3'(inflight) - 3'(pop);
      return (used < 3'd2);
   endfunction

endpackage

// File: rtl/stage2_conv_ofifo.sv
// Two-entry output FIFO; the head register drives the consumer directly so
// data stays stable while the consumer stalls.
module stage2_conv_ofifo
   import stage2_conv_ctrl_pkg::*;
#(
   parameter int W = 43
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         valid,
   output logic [1:0]   count
);

   logic [W-1:0] e0_r;
   logic [W-1:0] e1_r;
   logic [1:0]   cnt_r;
   logic         pop_s;

   assign pop_s = pop && (cnt_r != 2'd0);
   assign head  = e0_r;
   assign valid = (cnt_r != 2'd0);
   assign count = cnt_r;

   // Entry storage and occupancy; e0 is always the head.
   always_ff @(posedge clk) begin
      if (reset) begin
         e0_r  <= '0;
         e1_r  <= '0;
         cnt_r <= 2'd0;
      end else begin
         case ({push, pop_s})
            2'b10: begin
               if (cnt_r == 2'd0) begin
                  e0_r  <= push_data;
                  cnt_r <= 2'd1;
               end else if (cnt_r == 2'd1) begin
                  e1_r  <= push_data;
                  cnt_r <= 2'd2;
               end
            end
            2'b01: begin
               e0_r  <= e1_r;
               cnt_r <= cnt_r - 2'd1;
            end
            2'b11: begin
               if (cnt_r == 2'd1) begin
                  e0_r <= push_data;
               end else begin
                  e0_r <= e1_r;
                  e1_r <= push_data;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/stage2_conv_ctrl.sv
// Stage-2 convolution controller: issues (ch, x, y) kernel ops in raster order,
// sums per-channel results into pixels and buffers them in a 2-entry FIFO.
module stage2_conv_ctrl
   import stage2_conv_ctrl_pkg::*;
#(
   parameter int IN_CH = 3,
   parameter int OUT_W = 8,
   parameter int OUT_H = 8,
   parameter int AK_BW = 39,
   parameter int K_LAT = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_start,
   output logic                              o_busy,
   output logic                              o_done,
   output logic                              o_k_valid,
   output logic [3:0]                        o_ch,
   output logic [7:0]                        o_x,
   output logic [7:0]                        o_y,
   input  logic                              i_k_valid,
   input  logic signed [AK_BW-1:0]           i_k_acc,
   output logic                              o_ot_valid,
   input  logic                              i_ot_ready,
   output logic signed [AK_BW+AO_GUARD-1:0]  o_ot_data
);

   localparam int AO_BW = AK_BW + AO_GUARD;

   logic [1:0]              state_r, next_state_s;
   logic                    busy_r, done_r;
   logic [3:0]              ch_r;
   logic [7:0]              x_r, y_r;
   logic                    kv_r;
   logic [3:0]              kch_r;
   logic [7:0]              kx_r, ky_r;
   logic [K_LAT-1:0]        tag_vld_r, tag_first_r, tag_last_r;
   logic signed [AO_BW-1:0] acc_r;
   logic [1:0]              inflight_r;

   logic                    first_op_s, last_ch_s, last_x_s, last_y_s, last_op_s;
   logic                    issue_s, issue_first_s;
   logic                    accept_s, push_s, pop_s, drained_s;
   logic signed [AO_BW-1:0] ext_s, sum_s;
   logic [AO_BW-1:0]        fifo_head_s;
   logic                    fifo_valid_s;
   logic [1:0]              fifo_count_s;

   assign first_op_s    = (ch_r == 4'd0);
   assign last_ch_s     = (ch_r == 4'(IN_CH - 1));
   assign last_x_s      = (x_r == 8'(OUT_W - 1));
   assign last_y_s      = (y_r == 8'(OUT_H - 1));
   assign last_op_s     = last_ch_s && last_x_s && last_y_s;
   assign pop_s         = fifo_valid_s && i_ot_ready;
   assign issue_first_s = issue_s && first_op_s;
   assign accept_s      = i_k_valid && tag_vld_r[K_LAT-1];
   assign push_s        = accept_s && tag_last_r[K_LAT-1];
   assign ext_s         = {{AO_GUARD{i_k_acc[AK_BW-1]}}, i_k_acc};
   assign drained_s     = (inflight_r == 2'd0) && (fifo_count_s == 2'd0) &&
                          (tag_vld_r == '0) && !kv_r;

   // Only the first op of a pixel needs room reserved in the output buffer.
   always_comb begin
      issue_s = 1'b0;
      if (state_r == ST_RUN) begin
         issue_s = !first_op_s || has_credit(fifo_count_s, pop_s, inflight_r);
      end else begin
         issue_s = 1'b0;
      end
   end

   always_comb begin
      sum_s = ext_s;
      if (tag_first_r[K_LAT-1]) begin
         sum_s = ext_s;
      end else begin
         sum_s = acc_r + ext_s;
      end
   end

   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) next_state_s = ST_RUN;
            else         next_state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (issue_s && last_op_s) next_state_s = ST_DRAIN;
            else                      next_state_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (drained_s) next_state_s = ST_DONE;
            else           next_state_s = ST_DRAIN;
         end
         ST_DONE:  next_state_s = ST_IDLE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // Frame state and the registered status flags derived from it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == ST_RUN) || (next_state_s == ST_DRAIN);
         done_r  <= (next_state_s == ST_DONE);
      end
   end

   // Op counters (ch innermost) and the registered issue port.
   always_ff @(posedge clk) begin
      if (reset) begin
         ch_r  <= 4'd0;
         x_r   <= 8'd0;
         y_r   <= 8'd0;
         kv_r  <= 1'b0;
         kch_r <= 4'd0;
         kx_r  <= 8'd0;
         ky_r  <= 8'd0;
      end else begin
         kv_r <= issue_s;
         if (issue_s) begin
            kch_r <= ch_r;
            kx_r  <= x_r;
            ky_r  <= y_r;
            if (last_ch_s) begin
               ch_r <= 4'd0;
               if (last_x_s) begin
                  x_r <= 8'd0;
                  y_r <= last_y_s ? 8'd0 : y_r + 8'd1;
               end else begin
                  x_r <= x_r + 8'd1;
               end
            end else begin
               ch_r <= ch_r + 4'd1;
            end
         end
      end
   end

   // Shadow tags line up with kernel results K_LAT cycles after issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld_r   <= '0;
         tag_first_r <= '0;
         tag_last_r  <= '0;
      end else begin
         tag_vld_r[0]   <= kv_r;
         tag_first_r[0] <= (kch_r == 4'd0);
         tag_last_r[0]  <= (kch_r == 4'(IN_CH - 1));
         for (int i = 1; i < K_LAT; i++) begin
            tag_vld_r[i]   <= tag_vld_r[i-1];
            tag_first_r[i] <= tag_first_r[i-1];
            tag_last_r[i]  <= tag_last_r[i-1];
         end
      end
   end

   // Channel accumulator and count of pixels holding a buffer reservation.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r      <= '0;
         inflight_r <= 2'd0;
      end else begin
         if (accept_s) acc_r <= sum_s;
         case ({issue_first_s, push_s})
            2'b10:   inflight_r <= inflight_r + 2'd1;
            2'b01:   inflight_r <= inflight_r - 2'd1;
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   stage2_conv_ofifo #(.W(AO_BW)) u_ofifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (sum_s),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .valid     (fifo_valid_s),
      .count     (fifo_count_s)
   );

   assign o_busy     = busy_r;
   assign o_done     = done_r;
   assign o_k_valid  = kv_r;
   assign o_ch       = kch_r;
   assign o_x        = kx_r;
   assign o_y        = ky_r;
   assign o_ot_valid = fifo_valid_s;
   assign o_ot_data  = fifo_head_s;

endmodule

// File: tb/tb_stage2_conv_ctrl.sv
// Directed bench for stage2_conv_ctrl on a 2x2 frame with 3 channels and a
// K_LAT=2 kernel model whose result encodes the op's channel and position.
module tb_stage2_conv_ctrl;

   localparam int IN_CH = 3;
   localparam int OUT_W = 2;
   localparam int OUT_H = 2;
   localparam int AK_BW = 39;
   localparam int K_LAT = 2;
   localparam int AO_BW = AK_BW + 4;

   logic                    clk;
   logic                    reset;
   logic                    i_start;
   logic                    o_busy, o_done, o_k_valid;
   logic [3:0]              o_ch;
   logic [7:0]              o_x, o_y;
   logic                    i_k_valid;
   logic signed [AK_BW-1:0] i_k_acc;
   logic                    o_ot_valid;
   logic                    i_ot_ready;
   logic signed [AO_BW-1:0] o_ot_data;

   int total = 0;
   int bad   = 0;
   int kmode = 0;

   stage2_conv_ctrl #(.IN_CH(IN_CH), .OUT_W(OUT_W), .OUT_H(OUT_H),
                      .AK_BW(AK_BW), .K_LAT(K_LAT)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy),
      .o_done(o_done), .o_k_valid(o_k_valid), .o_ch(o_ch), .o_x(o_x),
      .o_y(o_y), .i_k_valid(i_k_valid), .i_k_acc(i_k_acc),
      .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready), .o_ot_data(o_ot_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Kernel model: two-stage delay of the issue port.
   logic       kv1, kv2;
   logic [3:0] kc1, kc2;
   logic [7:0] kx1, kx2, ky1, ky2;
   always @(posedge clk) begin
      kv1 <= o_k_valid; kc1 <= o_ch; kx1 <= o_x; ky1 <= o_y;
      kv2 <= kv1;       kc2 <= kc1;  kx2 <= kx1; ky2 <= ky1;
   end
   assign i_k_valid = kv2;
   always_comb begin
      if (kmode == 1)      i_k_acc = {1'b1, {(AK_BW-1){1'b0}}};
      else if (kmode == 2) i_k_acc = AK_BW'(int'(kc2) + 1 + 16 * int'(kx2) + 64 * int'(ky2));
      else                 i_k_acc = AK_BW'(int'(kc2) + 1);
   end

   // Output / issue monitor.
   logic signed [AO_BW-1:0] outs [0:63];
   int n_out = 0, n_done = 0, n_kv = 0, run_kv = 0, max_run = 0, cyc = 0;
   int first_kv = -1, first_ot = -1;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (o_ot_valid === 1'b1 && i_ot_ready === 1'b1) begin
         if (n_out < 64) outs[n_out] = o_ot_data;
         n_out = n_out + 1;
         if (first_ot < 0) first_ot = cyc;
      end
      if (o_done === 1'b1) n_done = n_done + 1;
      if (o_k_valid === 1'b1) begin
         n_kv = n_kv + 1;
         run_kv = run_kv + 1;
         if (run_kv > max_run) max_run = run_kv;
         if (first_kv < 0) first_kv = cyc;
      end else begin
         run_kv = 0;
      end
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] pix(input int p);
      return 64'(6 + 48 * (p % OUT_W) + 192 * (p / OUT_W));
   endfunction

   // rmode 0: ready high, 1: ready low, 2: ready toggles every cycle.
   task automatic run_frame(input int rmode, input int budget, output bit timed_out);
      int d0;
      d0 = n_done;
      timed_out = 1'b1;
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (rmode == 0)      i_ot_ready = 1'b1;
         else if (rmode == 1) i_ot_ready = 1'b0;
         else                 i_ot_ready = ~i_ot_ready;
         if (n_done > d0) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      i_ot_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit to;
      int b_out, b_done, b_kv;
      reset = 1'b1; i_start = 1'b0; i_ot_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_kvalid", o_k_valid, 0);
      check("rst_chxy", {o_ch, o_x, o_y}, 0);
      check("rst_otvalid", o_ot_valid, 0);
      check("rst_otdata", o_ot_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic frame: every pixel sums to 1+2+3.
      kmode = 0; b_out = n_out; b_done = n_done; b_kv = n_kv;
      run_frame(0, 200, to);
      check("f1_timeout", to, 0);
      check("f1_nout", n_out - b_out, 4);
      for (int i = 0; i < 4; i++) check("f1_data", outs[b_out + i], 6);
      check("f1_ndone", n_done - b_done, 1);
      check("f1_nkv", n_kv - b_kv, 12);
      check("f1_kv_run", max_run, 12);
      check("f1_latency", first_ot - first_kv, 5);
      check("f1_idle", o_busy, 0);

      // Most negative kernel results on every channel.
      kmode = 1; b_out = n_out;
      run_frame(0, 200, to);
      check("neg_timeout", to, 0);
      check("neg_nout", n_out - b_out, 4);
      check("neg_first", outs[b_out], -64'sd3 * (64'sd1 <<< 38));
      check("neg_last", outs[b_out + 3], -64'sd3 * (64'sd1 <<< 38));

      // Consumer stalled: only two pixels may be issued.
      kmode = 2; b_out = n_out; b_done = n_done; b_kv = n_kv;
      @(negedge clk); i_start = 1'b1; i_ot_ready = 1'b0;
      @(negedge clk); i_start = 1'b0;
      repeat (40) @(negedge clk);
      check("stall_nkv", n_kv - b_kv, 6);
      check("stall_kvalid", o_k_valid, 0);
      check("stall_otvalid", o_ot_valid, 1);
      check("stall_data", o_ot_data, pix(0));
      repeat (5) @(negedge clk);
      check("stall_hold_valid", o_ot_valid, 1);
      check("stall_hold_data", o_ot_data, pix(0));
      check("stall_busy", o_busy, 1);
      i_ot_ready = 1'b1;
      for (int c = 0; c < 200 && n_done == b_done; c++) @(negedge clk);
      check("stall_ndone", n_done - b_done, 1);
      check("stall_nout", n_out - b_out, 4);
      for (int i = 0; i < 4; i++) check("stall_order", outs[b_out + i], pix(i));
      check("stall_nkv_total", n_kv - b_kv, 12);

      // Ready toggling every cycle.
      b_out = n_out; b_done = n_done;
      run_frame(2, 300, to);
      check("tog_timeout", to, 0);
      check("tog_nout", n_out - b_out, 4);
      for (int i = 0; i < 4; i++) check("tog_order", outs[b_out + i], pix(i));
      check("tog_ndone", n_done - b_done, 1);

      // Reset in the middle of a frame.
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_busy", o_busy, 0);
      check("mid_kvalid", o_k_valid, 0);
      check("mid_chxy", {o_ch, o_x, o_y}, 0);
      check("mid_otvalid", o_ot_valid, 0);
      check("mid_otdata", o_ot_data, 0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_stale_valid", o_ot_valid, 0);
      check("mid_stale_busy", o_busy, 0);
      b_out = n_out; b_done = n_done;
      run_frame(0, 200, to);
      check("mid_timeout", to, 0);
      check("mid_nout", n_out - b_out, 4);
      for (int i = 0; i < 4; i++) check("mid_order", outs[b_out + i], pix(i));

      // Extra start pulses while running must be ignored.
      b_out = n_out; b_done = n_done;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      repeat (3) @(negedge clk);
      check("dbl_busy", o_busy, 1);
      i_start = 1'b1; @(negedge clk); i_start = 1'b0;
      repeat (4) @(negedge clk);
      i_start = 1'b1; @(negedge clk); i_start = 1'b0;
      for (int c = 0; c < 200 && n_done == b_done; c++) @(negedge clk);
      repeat (30) @(negedge clk);
      check("dbl_ndone", n_done - b_done, 1);
      check("dbl_nout", n_out - b_out, 4);
      check("dbl_idle", o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
